clk_step_ctrl: RTL

//  Run/halt/single-step controller for the FakeCPU core clock. Divides clkin into a
//  one-cycle CPU clock-enable (cpu_ce) at TICK_DIV spacing and gates it by a control FSM.

---
 rtl/clk_step_ctrl_pkg.sv | 11 +
 rtl/clk_step_ctrl_if.sv | 31 +++
 rtl/clk_tick_div.sv | 29 ++
 rtl/clk_step_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/clk_step_ctrl_pkg.sv
// Shared types for the FakeCPU run/halt/step clock controller.
// Holds the controller state encoding used by the top-level FSM.
package clk_step_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

endpackage

// File: rtl/clk_step_ctrl_if.sv
// Control/status bundle between the button/debug side and clk_step_ctrl.
// master: drives requests, step count, breakpoint and pc; slave: the controller.
interface clk_step_ctrl_if #(
    parameter int AW = 16,
    parameter int CW = 8
);
    logic          run_req;
    logic          halt_req;
    logic          step_req;
    logic [CW-1:0] step_cnt;
    logic          bp_en;
    logic [AW-1:0] bp_addr;
    logic [AW-1:0] pc;
    logic          cpu_ce;
    logic          running;
    logic          halted;
    logic          bp_hit;
    logic [31:0]   cyc_count;

    modport master (
        output run_req, halt_req, step_req, step_cnt,
        output bp_en, bp_addr, pc,
        input  cpu_ce, running, halted, bp_hit, cyc_count
    );

    modport slave (
        input  run_req, halt_req, step_req, step_cnt,
        input  bp_en, bp_addr, pc,
        output cpu_ce, running, halted, bp_hit, cyc_count
    );
endinterface

// File: rtl/clk_tick_div.sv
// Free-running clkin divider producing a terminal-count tick every TICK_DIV cycles.
// Ports: clkin, rst (sync, active-low), en, clr -> tick (comb, div==TICK_DIV-1 && en).
module clk_tick_div #(
    parameter int TICK_DIV = 50000
) (
    input  logic clkin,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(TICK_DIV - 1);

    logic [DW-1:0] div;

    assign tick = en && (div == LAST);

    // Counter sits at zero whenever disabled so every run/step starts on a fresh phase.
    always_ff @(posedge clkin) begin
        if (!rst) begin
            div <= '0;
        end else if (clr || !en || tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end
endmodule

// File: rtl/clk_step_ctrl.sv
// Run/halt/single-step/breakpoint controller gating a divided CPU clock-enable.
// Ports: clkin, rst (sync, active-low), bus (slave: requests in, cpu_ce/status out).
module clk_step_ctrl
    import clk_step_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int AW       = 16,
    parameter int CW       = 8
) (
    input  logic            clkin,
    input  logic            rst,
    clk_step_ctrl_if.slave  bus
);
    state_t        state, state_n;
    logic [CW-1:0] remaining, rem_n;
    logic          skip_bp, skip_n;
    logic          hit_n, ce_n;
    logic          run_q, halt_q, step_q;
    logic          rise_run, rise_halt, rise_step;
    logic          tick, clr;
    logic          bp_match;

    assign rise_run  = bus.run_req  & ~run_q;
    assign rise_halt = bus.halt_req & ~halt_q;
    assign rise_step = bus.step_req & ~step_q;

    assign bp_match = bus.bp_en && (AW'(bus.pc) == AW'(bus.bp_addr));

    clk_tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_div (
        .clkin (clkin),
        .rst   (rst),
        .en    (state != ST_HALT),
        .clr   (clr),
        .tick  (tick)
    );

    always_comb begin
        state_n = state;
        rem_n   = remaining;
        skip_n  = skip_bp;
        hit_n   = bus.bp_hit;
        ce_n    = 1'b0;
        clr     = 1'b0;
        unique case (state)
            ST_HALT: begin
                if (!rise_halt && (rise_step || rise_run)) begin
                    state_n = rise_step ? ST_STEP : ST_RUN;
                    clr     = 1'b1;
                    skip_n  = 1'b1;
                    hit_n   = 1'b0;
                    if (rise_step) begin
                        rem_n = (bus.step_cnt == '0) ? CW'(1) : CW'(bus.step_cnt);
                    end
                end
            end
            ST_RUN: begin
                if (rise_halt) begin
                    state_n = ST_HALT;
                    clr     = 1'b1;
                end else if (tick) begin
                    skip_n = 1'b0;
                    if (bp_match && !skip_bp) begin
                        state_n = ST_HALT;
                        hit_n   = 1'b1;
                    end else begin
                        ce_n = 1'b1;
                    end
                end
            end
            ST_STEP: begin
                if (rise_halt) begin
                    state_n = ST_HALT;
                    clr     = 1'b1;
                end else begin
                    // A run edge converts the step into free-run without disturbing phase.
                    if (rise_run) begin
                        state_n = ST_RUN;
                    end
                    if (tick) begin
                        skip_n = 1'b0;
                        ce_n   = 1'b1;
                        rem_n  = remaining - 1'b1;
                        if (remaining == CW'(1) && !rise_run) begin
                            state_n = ST_HALT;
                        end
                    end
                end
            end
            default: begin
                state_n = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clkin) begin
        if (!rst) begin
            state         <= ST_HALT;
            remaining     <= '0;
            skip_bp       <= 1'b0;
            run_q         <= 1'b1;
            halt_q        <= 1'b1;
            step_q        <= 1'b1;
            bus.cpu_ce    <= 1'b0;
            bus.running   <= 1'b0;
            bus.halted    <= 1'b1;
            bus.bp_hit    <= 1'b0;
            bus.cyc_count <= '0;
        end else begin
            state         <= state_n;
            remaining     <= rem_n;
            skip_bp       <= skip_n;
            run_q         <= bus.run_req;
            halt_q        <= bus.halt_req;
            step_q        <= bus.step_req;
            bus.cpu_ce    <= ce_n;
            bus.running   <= (state_n != ST_HALT);
            bus.halted    <= (state_n == ST_HALT);
            bus.bp_hit    <= hit_n;
            if (ce_n) begin
                bus.cyc_count <= bus.cyc_count + 32'd1;
            end
        end
    end
endmodule
